// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by a word-addressed register-file memory
// Parameters: C_ADDR_WIDTH byte-address width (depth 2^(C_ADDR_WIDTH-2) words),
//             C_LEN_WIDTH AxLEN width
// Clock/reset: ACLK rising edge, ARESETN asynchronous active-low
// AW channel : AWADDR, AWLEN, AWBURST, AWVALID -> AWREADY
// W channel  : WDATA, WSTRB, WLAST, WVALID -> WREADY
// B channel  : BRESP, BVALID <- BREADY
// AR channel : ARADDR, ARLEN, ARBURST, ARVALID -> ARREADY
// R channel  : RDATA, RRESP, RLAST, RVALID <- RREADY
module axi_slave_mem #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_LEN_WIDTH  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [C_ADDR_WIDTH-1:0] AWADDR,
  input  logic [C_LEN_WIDTH-1:0]  AWLEN,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [31:0]             WDATA,
  input  logic [3:0]              WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [C_ADDR_WIDTH-1:0] ARADDR,
  input  logic [C_LEN_WIDTH-1:0]  ARLEN,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [31:0]             RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int AW = C_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << AW;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_ADDR, R_DATA} rstate_t;
  logic [31:0] mem [DEPTH];
  logic init;
  wstate_t wstate;
  rstate_t rstate;
  logic [AW-1:0] waddr, raddr, ar_word;
  logic [C_LEN_WIDTH-1:0] wlen, wcnt, rlen, rcnt, rnext;
  logic winc, werr, wlerr, wlast_beat, wbad, rinc, rerr;
  logic unused_lsbs;
  assign unused_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};
  assign wlast_beat = wcnt == wlen;
  assign wbad = WLAST != wlast_beat;
  assign ar_word = ARADDR[C_ADDR_WIDTH-1:2];
  assign rnext = rcnt + 1'b1;
  // Delays the address READYs by one extra edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) init <= 1'b0;
    else init <= 1'b1;
  // werr (unsupported burst) suppresses writes; wlerr (WLAST mismatch) only affects BRESP.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate  <= W_ADDR;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
      waddr   <= '0;
      wlen    <= '0;
      wcnt    <= '0;
      winc    <= 1'b0;
      werr    <= 1'b0;
      wlerr   <= 1'b0;
    end else begin
      case (wstate)
        W_ADDR:
          if (!AWREADY) AWREADY <= init;
          else if (AWVALID) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            waddr   <= AWADDR[C_ADDR_WIDTH-1:2];
            wlen    <= AWLEN;
            wcnt    <= '0;
            winc    <= AWBURST == 2'b01;
            werr    <= AWBURST[1];
            wlerr   <= 1'b0;
            wstate  <= W_DATA;
          end
        W_DATA:
          if (WVALID) begin
            waddr <= waddr + AW'(winc);
            wcnt  <= wcnt + 1'b1;
            wlerr <= wlerr | wbad;
            if (wlast_beat) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BRESP  <= (werr | wlerr | wbad) ? 2'b10 : 2'b00;
              wstate <= W_RESP;
            end
          end
        W_RESP:
          if (BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= 2'b00;
            AWREADY <= 1'b1;
            wstate  <= W_ADDR;
          end
        default: wstate <= W_ADDR;
      endcase
    end
  end
  always_ff @(posedge ACLK)
    if (wstate == W_DATA && WVALID && !werr)
      for (int i = 0; i < 4; i++)
        if (WSTRB[i]) mem[waddr][8*i +: 8] <= WDATA[8*i +: 8];
  // raddr always holds the word to load for the next beat.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate  <= R_ADDR;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= 2'b00;
      RLAST   <= 1'b0;
      raddr   <= '0;
      rlen    <= '0;
      rcnt    <= '0;
      rinc    <= 1'b0;
      rerr    <= 1'b0;
    end else begin
      case (rstate)
        R_ADDR:
          if (!ARREADY) ARREADY <= init;
          else if (ARVALID) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RDATA   <= ARBURST[1] ? '0 : mem[ar_word];
            RRESP   <= ARBURST[1] ? 2'b10 : 2'b00;
            RLAST   <= ARLEN == '0;
            raddr   <= ar_word + AW'(ARBURST == 2'b01);
            rlen    <= ARLEN;
            rcnt    <= '0;
            rinc    <= ARBURST == 2'b01;
            rerr    <= ARBURST[1];
            rstate  <= R_DATA;
          end
        R_DATA:
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              RDATA   <= '0;
              RRESP   <= 2'b00;
              ARREADY <= 1'b1;
              rstate  <= R_ADDR;
            end else begin
              RDATA <= rerr ? '0 : mem[raddr];
              raddr <= raddr + AW'(rinc);
              rcnt  <= rnext;
              RLAST <= rnext == rlen;
            end
          end
        default: rstate <= R_ADDR;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed self-checking bench for axi_slave_mem
module tb_axi_slave_mem;
  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic [11:0] AWADDR = '0, ARADDR = '0;
  logic [7:0] AWLEN = '0, ARLEN = '0;
  logic [1:0] AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [31:0] WDATA = '0, RDATA;
  logic [3:0] WSTRB = '0;
  int tests = 0, fails = 0, tmo = 0;
  logic [31:0] wd [16];
  logic [3:0] ws [16];
  logic [31:0] rd [16];
  logic [1:0] rr [16];
  logic rl [16];
  int rn, rcyc, stab;
  logic aw_after_b, ar_after;
  logic [1:0] resp;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // wlm: 0 correct WLAST, 1 WLAST on beat 0 only, 2 WLAST never
  task automatic do_write(input logic [11:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input int wlm, output logic [1:0] r);
    int n;
    AWADDR = a; AWLEN = len; AWBURST = burst; AWVALID = 1; n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    if (n == 20) tmo++;
    @(posedge ACLK); #1; AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WVALID = 1;
      WLAST = (wlm == 0) ? (i == int'(len)) : (wlm == 1) ? (i == 0) : 1'b0;
      n = 0;
      while (WREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
      if (n == 20) tmo++;
      @(posedge ACLK); #1;
    end
    WVALID = 0; WLAST = 0; n = 0;
    while (BVALID !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    if (n == 20) tmo++;
    r = BRESP; BREADY = 1;
    @(posedge ACLK); #1; BREADY = 0; aw_after_b = AWREADY;
  endtask

  // pat[cycle%4] drives RREADY; records beats, cycles taken and stall instabilities
  task automatic do_read(input logic [11:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] pat);
    int n;
    logic stall, pl;
    logic [31:0] pdat;
    ARADDR = a; ARLEN = len; ARBURST = burst; ARVALID = 1; n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    if (n == 20) tmo++;
    @(posedge ACLK); #1; ARVALID = 0;
    rn = 0; rcyc = 0; stab = 0; stall = 0; pdat = '0; pl = 0;
    while (rcyc < 100 && rn < 16) begin
      RREADY = pat[rcyc % 4];
      if (stall && (RDATA !== pdat || RLAST !== pl)) stab++;
      stall = RVALID && !RREADY; pdat = RDATA; pl = RLAST;
      if (RVALID && RREADY) begin rd[rn] = RDATA; rr[rn] = RRESP; rl[rn] = RLAST; rn++; end
      @(posedge ACLK); #1; rcyc++;
      if (rn > 0 && rl[rn-1] === 1'b1) break;
    end
    RREADY = 0; ar_after = ARREADY;
    if (rn == 0 || rl[rn-1] !== 1'b1) tmo++;
  endtask

  task automatic test_reset;
    ARESETN = 0;
    repeat (3) @(posedge ACLK);
    #1;
    tests++; if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST, RDATA} !== 42'd0) begin
      fails++; $display("FAIL reset_outputs got %h want 0", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST, RDATA}); end
    ARESETN = 1;
    @(posedge ACLK); #1;
    tests++; if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST, RDATA} !== 42'd0) begin
      fails++; $display("FAIL reset_first_cycle got %h want 0", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST, RDATA}); end
    @(posedge ACLK); #1;
    tests++; if ({AWREADY, ARREADY} !== 2'b11) begin
      fails++; $display("FAIL reset_ready_second_edge got %b want 11", {AWREADY, ARREADY}); end
  endtask

  task automatic test_single;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(12'h010, 8'd0, 2'b01, 0, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL single_bresp got %b want 00", resp); end
    tests++; if (aw_after_b !== 1'b1) begin fails++; $display("FAIL aw_turnaround got %b want 1", aw_after_b); end
    do_read(12'h010, 8'd0, 2'b01, 4'hF);
    tests++; if (rn != 1) begin fails++; $display("FAIL single_beats got %0d want 1", rn); end
    tests++; if (rd[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data got %h want deadbeef", rd[0]); end
    tests++; if ({rl[0], rr[0]} !== 3'b100) begin fails++; $display("FAIL single_last_resp got %b want 100", {rl[0], rr[0]}); end
    tests++; if (ar_after !== 1'b1) begin fails++; $display("FAIL ar_turnaround got %b want 1", ar_after); end
  endtask

  task automatic test_incr;
    logic [31:0] e [4];
    e = '{32'h1111AAAA, 32'h22222222, 32'h33333333, 32'h44444444};
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(12'h100, 8'd3, 2'b01, 0, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL incr_bresp got %b want 00", resp); end
    wd[0] = 32'hAAAAAAAA; ws[0] = 4'h3;
    do_write(12'h100, 8'd0, 2'b01, 0, resp);
    do_read(12'h100, 8'd3, 2'b01, 4'hF);
    tests++; if (rcyc != 4) begin fails++; $display("FAIL incr_no_bubbles got %0d cycles want 4", rcyc); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (rd[i] !== e[i]) begin fails++; $display("FAIL incr_data[%0d] got %h want %h", i, rd[i], e[i]); end
    end
    tests++; if ({rl[0], rl[1], rl[2], rl[3]} !== 4'b0001) begin
      fails++; $display("FAIL incr_rlast got %b want 0001", {rl[0], rl[1], rl[2], rl[3]}); end
  endtask

  task automatic test_backpressure;
    do_read(12'h100, 8'd3, 2'b01, 4'b1001);
    tests++; if (rn != 4) begin fails++; $display("FAIL bp_beats got %0d want 4", rn); end
    tests++; if (stab != 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", stab); end
    tests++; if ({rl[0], rl[1], rl[2], rl[3]} !== 4'b0001) begin
      fails++; $display("FAIL bp_rlast got %b want 0001", {rl[0], rl[1], rl[2], rl[3]}); end
    tests++; if ({rd[0], rd[3]} !== {32'h1111AAAA, 32'h44444444}) begin
      fails++; $display("FAIL bp_data got %h %h want 1111aaaa 44444444", rd[0], rd[3]); end
  endtask

  task automatic test_fixed;
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    for (int i = 0; i < 3; i++) ws[i] = 4'hF;
    do_write(12'h020, 8'd2, 2'b00, 0, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL fixed_bresp got %b want 00", resp); end
    do_read(12'h020, 8'd1, 2'b00, 4'hF);
    tests++; if ({rd[0], rd[1]} !== {32'd3, 32'd3}) begin fails++; $display("FAIL fixed_data got %h %h want 3 3", rd[0], rd[1]); end
  endtask

  task automatic test_unsupported;
    wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(12'h040, 8'd1, 2'b01, 0, resp);
    wd[0] = 32'h77; wd[1] = 32'h88;
    do_write(12'h040, 8'd1, 2'b10, 0, resp);
    tests++; if (resp !== 2'b10) begin fails++; $display("FAIL wrap_write_bresp got %b want 10", resp); end
    do_read(12'h040, 8'd1, 2'b01, 4'hF);
    tests++; if ({rd[0], rd[1]} !== {32'h55, 32'h66}) begin fails++; $display("FAIL wrap_write_mem got %h %h want 55 66", rd[0], rd[1]); end
    do_read(12'h040, 8'd1, 2'b10, 4'hF);
    tests++; if (rn != 2) begin fails++; $display("FAIL wrap_read_beats got %0d want 2", rn); end
    tests++; if ({rd[0], rd[1]} !== 64'd0) begin fails++; $display("FAIL wrap_read_data got %h %h want 0 0", rd[0], rd[1]); end
    tests++; if ({rr[0], rr[1]} !== 4'b1010) begin fails++; $display("FAIL wrap_read_rresp got %b want 1010", {rr[0], rr[1]}); end
  endtask

  task automatic test_wraparound;
    wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(12'hFFC, 8'd1, 2'b01, 0, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL wraparound_bresp got %b want 00", resp); end
    do_read(12'h000, 8'd0, 2'b01, 4'hF);
    tests++; if (rd[0] !== 32'h5A5A5A5A) begin fails++; $display("FAIL wraparound_000 got %h want 5a5a5a5a", rd[0]); end
    do_read(12'hFFC, 8'd1, 2'b01, 4'hF);
    tests++; if ({rd[0], rd[1], rr[1]} !== {32'hA5A5A5A5, 32'h5A5A5A5A, 2'b00}) begin
      fails++; $display("FAIL wraparound_read got %h %h %b want a5a5a5a5 5a5a5a5a 00", rd[0], rd[1], rr[1]); end
  endtask

  task automatic test_wlast;
    wd[0] = 32'h61; wd[1] = 32'h62; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(12'h060, 8'd1, 2'b01, 1, resp);
    tests++; if (resp !== 2'b10) begin fails++; $display("FAIL wlast_early_bresp got %b want 10", resp); end
    do_read(12'h060, 8'd1, 2'b01, 4'hF);
    tests++; if ({rd[0], rd[1]} !== {32'h61, 32'h62}) begin fails++; $display("FAIL wlast_early_mem got %h %h want 61 62", rd[0], rd[1]); end
    do_write(12'h068, 8'd1, 2'b01, 2, resp);
    tests++; if (resp !== 2'b10) begin fails++; $display("FAIL wlast_missing_bresp got %b want 10", resp); end
    do_write(12'h068, 8'd1, 2'b01, 0, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL wlast_ok_after_err got %b want 00", resp); end
  endtask

  task automatic test_reset_mid;
    int n, seen;
    AWADDR = 12'h080; AWLEN = 8'd3; AWBURST = 2'b01; AWVALID = 1; n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    if (n == 20) tmo++;
    @(posedge ACLK); #1; AWVALID = 0;
    for (int i = 0; i < 2; i++) begin
      WDATA = 32'h801 + i; WSTRB = 4'hF; WLAST = 0; WVALID = 1;
      @(posedge ACLK); #1;
    end
    WVALID = 0; ARESETN = 0; #1;
    tests++; if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
      fails++; $display("FAIL midreset_async got %b want 000", {AWREADY, WREADY, BVALID}); end
    seen = 0;
    repeat (3) begin @(posedge ACLK); #1; if (BVALID !== 1'b0) seen++; end
    ARESETN = 1;
    @(posedge ACLK); #1;
    if (BVALID !== 1'b0) seen++;
    tests++; if (AWREADY !== 1'b0) begin fails++; $display("FAIL midreset_first_edge got %b want 0", AWREADY); end
    @(posedge ACLK); #1;
    if (BVALID !== 1'b0) seen++;
    tests++; if (AWREADY !== 1'b1) begin fails++; $display("FAIL midreset_second_edge got %b want 1", AWREADY); end
    tests++; if (seen != 0) begin fails++; $display("FAIL midreset_bvalid got %0d cycles want 0", seen); end
    do_read(12'h080, 8'd1, 2'b01, 4'hF);
    tests++; if ({rd[0], rd[1]} !== {32'h801, 32'h802}) begin fails++; $display("FAIL midreset_mem got %h %h want 801 802", rd[0], rd[1]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_incr;
    test_backpressure;
    test_fixed;
    test_unsupported;
    test_wraparound;
    test_wlast;
    test_reset_mid;
    tests++; if (tmo != 0) begin fails++; $display("FAIL handshake_timeouts got %0d want 0", tmo); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
